axis_asym_fifo: RTL and testbench
=================================

// Module: axis_asym_fifo
// PURPOSE
//  Single-clock AXI-stream FIFO with width down-conversion. Each accepted wide input word is
//  stored whole. It is then emitted as R = DATA_WIDTH_IN/DATA_WIDTH_OUT narrow output beats,
//  least-significant slice first.
//  Used after symbol demappers: a {LLR_Q, LLR_I} pair goes in and serial LLRs (I, then Q) come out.
// PARAMETERS
//  DATA_WIDTH_IN    16  input tdata width; integer multiple of DATA_WIDTH_OUT; R is a power of 2
//  DATA_WIDTH_OUT    8  output tdata width
//  ADDRESS_WIDTH_IN 10  log2 of depth, counted in input words (depth = 1024 words)
//  USER_WIDTH_IN     4  input tuser width; must be divisible by R
//  derived: R = DATA_WIDTH_IN/DATA_WIDTH_OUT; USER_WIDTH_OUT = USER_WIDTH_IN/R;
//           LEVEL_W = ADDRESS_WIDTH_IN + $clog2(R) + 1
// PORTS
//  clk_i              in   1               single clock, all logic on rising edge
//  reset_i            in   1               synchronous reset, active-high
//  s_axis_in_tdata    in   DATA_WIDTH_IN   wide input word
//  s_axis_in_tuser    in   USER_WIDTH_IN   sideband, sliced like tdata
//  s_axis_in_tlast    in   1               packet end, attached to the word's last output beat
//  s_axis_in_tvalid   in   1               write strobe (no tready on the input side)
//  s_axis_in_tfull    out  1               FIFO holds 2**ADDRESS_WIDTH_IN words
//  m_axis_out_tready  in   1               downstream accept
//  m_axis_out_tdata   out  DATA_WIDTH_OUT  current slice
//  m_axis_out_tuser   out  USER_WIDTH_OUT  current user slice
//  m_axis_out_tlast   out  1               last slice of a word written with tlast=1
//  m_axis_out_tvalid  out  1               output beat available
//  m_axis_out_tlevel  out  LEVEL_W         output beats stored (all whole words minus slices sent)
//  m_axis_out_tempty  out  1               = !m_axis_out_tvalid
// BEHAVIOUR
//  - Reset (clk_i edge with reset_i=1) clears wr_ptr, rd_ptr, word count and slice index sub.
//    Outputs after reset: tvalid=0, tlast=0, tempty=1, tfull=0, tlevel=0.
//    tdata/tuser are don't-care while tvalid=0. Memory contents are not cleared.
//  - Write: when s_axis_in_tvalid=1 and tfull=0, {tdata, tuser, tlast} is stored at wr_ptr.
//    wr_ptr wraps modulo depth.
//  - A write while tfull=1 is dropped silently. This holds even if a read frees space in the same cycle,
//    because tfull is evaluated from the state registered before the edge.
//  - Output is first-word-fall-through. tvalid = (count != 0).
//    A word written at edge N is presented from edge N (visible in cycle N+1); latency 1 clk.
//  - tdata = mem[rd_ptr].data[sub*DATA_WIDTH_OUT +: DATA_WIDTH_OUT].
//    tuser = mem[rd_ptr].user[sub*USER_WIDTH_OUT +: USER_WIDTH_OUT].
//  - tlast = mem[rd_ptr].last && (sub == R-1).
//  - Handshake: a beat transfers when tvalid && tready; sub is then incremented.
//    At sub==R-1 the beat also sets sub=0, increments rd_ptr (wrapping) and frees one word.
//  - tready=0 holds tdata/tuser/tlast stable. tready may be tied high.
//  - Simultaneous write and final-slice read: count is unchanged, both pointers advance.
//    Write into empty plus read in the same cycle: the read is ignored, because tvalid was 0.
//  - Levels and flags: tlevel = count*R - sub. tfull = (count == 2**ADDRESS_WIDTH_IN).
//  - If R==1 the block degenerates to a plain FIFO with sub held at 0.
//  - Reset mid-stream discards all stored words and any partially sent word.
// TESTING
//  1 Reset: hold reset_i=1 for 3 clks -> tvalid=0, tempty=1, tfull=0, tlevel=0.
//  2 Order: write 16'hB2A1 (user 4'b0101, last=1), tready=1.
//    -> beat 8'hA1 user 2'b01 last=0, then 8'hB2 user 2'b01 last=1; tlevel 2 -> 1 -> 0.
//  3 Backpressure: write 3 words, tready=0 for 10 clks.
//    -> tdata stays low slice of word0, tlevel=6; release -> 6 beats in order, no gaps.
//  4 Full: tready=0, write 1025 words.
//    -> tfull=1 after 1024 writes, word 1025 lost; drain reads words 0..1023 exactly.
//  5 Concurrent: continuous write and read at 1 word per 2 clks, 5000 words.
//    -> pointer wrap verified, no loss or duplication, tlevel bounded.
//  6 Mid-stream reset: assert reset_i after the first slice of a word.
//    -> next cycle tvalid=0, tlevel=0; new writes stream correctly.

Source files
------------

// File: rtl/axis_asym_fifo.sv
// axis_asym_fifo: single-clock AXI-stream FIFO with width down-conversion.
// Each accepted wide word is stored whole. It is then emitted as R narrow beats,
// least-significant slice first. The sideband (tuser) is sliced the same way.
// tlast rides on the final beat of a word that was written with tlast set.
//
// Handshake: the input side is a plain write strobe with no tready. A write
// with s_axis_in_tvalid=1 while s_axis_in_tfull=1 is dropped. On the output
// side a beat transfers on a rising edge where m_axis_out_tvalid &&
// m_axis_out_tready. While tready is low, tdata/tuser/tlast are held stable.
// tvalid never depends on tready.
module axis_asym_fifo #(
  parameter int DATA_WIDTH_IN    = 16,
  parameter int DATA_WIDTH_OUT   = 8,
  parameter int ADDRESS_WIDTH_IN = 10,
  parameter int USER_WIDTH_IN    = 4,
  parameter int R                = DATA_WIDTH_IN / DATA_WIDTH_OUT,
  parameter int USER_WIDTH_OUT   = USER_WIDTH_IN / R,
  parameter int LEVEL_W          = ADDRESS_WIDTH_IN + $clog2(R) + 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [DATA_WIDTH_IN-1:0]  s_axis_in_tdata,
  input  logic [USER_WIDTH_IN-1:0]  s_axis_in_tuser,
  input  logic                      s_axis_in_tlast,
  input  logic                      s_axis_in_tvalid,
  output logic                      s_axis_in_tfull,
  input  logic                      m_axis_out_tready,
  output logic [DATA_WIDTH_OUT-1:0] m_axis_out_tdata,
  output logic [USER_WIDTH_OUT-1:0] m_axis_out_tuser,
  output logic                      m_axis_out_tlast,
  output logic                      m_axis_out_tvalid,
  output logic [LEVEL_W-1:0]        m_axis_out_tlevel,
  output logic                      m_axis_out_tempty
);

  localparam int DEPTH     = 1 << ADDRESS_WIDTH_IN;
  localparam int CNT_W     = ADDRESS_WIDTH_IN + 1;
  localparam int SUB_SHIFT = $clog2(R);
  localparam int SUB_W     = (R > 1) ? $clog2(R) : 1;
  localparam int MEM_W     = 1 + USER_WIDTH_IN + DATA_WIDTH_IN;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(R - 1);

  // Word layout in memory: {last, user, data}
  logic [MEM_W-1:0]            mem [DEPTH];
  logic [ADDRESS_WIDTH_IN-1:0] wr_ptr;
  logic [ADDRESS_WIDTH_IN-1:0] rd_ptr;
  logic [CNT_W-1:0]            count;
  logic [SUB_W-1:0]            sub;

  logic                        wr_en;
  logic                        rd_beat;
  logic                        word_done;
  logic [MEM_W-1:0]            rd_word;
  logic [DATA_WIDTH_OUT-1:0]   data_slices [R];
  logic [USER_WIDTH_OUT-1:0]   user_slices [R];

  // Status and transfer qualifiers, all from registered state
  always_comb begin
    s_axis_in_tfull   = (count == CNT_W'(DEPTH));
    m_axis_out_tvalid = (count != '0);
    m_axis_out_tempty = (count == '0);
    wr_en             = s_axis_in_tvalid && !s_axis_in_tfull;
    rd_beat           = m_axis_out_tvalid && m_axis_out_tready;
    word_done         = rd_beat && (sub == SUB_LAST);
    m_axis_out_tlevel = (LEVEL_W'(count) << SUB_SHIFT) - LEVEL_W'(sub);
  end

  // Storage write; contents are intentionally never cleared
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr] <= {s_axis_in_tlast, s_axis_in_tuser, s_axis_in_tdata};
    end
  end

  // Pointer, word count and slice index bookkeeping
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      sub    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (word_done) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !word_done) begin
        count <= count + 1'b1;
      end else if (!wr_en && word_done) begin
        count <= count - 1'b1;
      end
      if (word_done) begin
        sub <= '0;
      end else if (rd_beat) begin
        sub <= sub + 1'b1;
      end
    end
  end

  assign rd_word = mem[rd_ptr];

  // Split the head word into per-beat slices
  for (genvar g = 0; g < R; g++) begin : g_slice
    assign data_slices[g] = rd_word[g*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
    assign user_slices[g] = rd_word[DATA_WIDTH_IN + g*USER_WIDTH_OUT +: USER_WIDTH_OUT];
  end

  // Present the current slice of the head word (first-word-fall-through)
  always_comb begin
    m_axis_out_tdata = data_slices[sub];
    m_axis_out_tuser = user_slices[sub];
    m_axis_out_tlast = rd_word[MEM_W-1] && (sub == SUB_LAST) && m_axis_out_tvalid;
  end

endmodule

// File: tb/tb_axis_asym_fifo.sv
// Bench for axis_asym_fifo. The reference model keeps the expected narrow
// beats in a queue. Every accepted wide word appends R beats. Every output
// handshake pops one beat. Level, full and valid are derived from the queue length.
module tb_axis_asym_fifo;

  localparam int DWI   = 16;
  localparam int DWO   = 8;
  localparam int AW    = 10;
  localparam int UWI   = 4;
  localparam int R     = DWI / DWO;
  localparam int UWO   = UWI / R;
  localparam int LW    = AW + $clog2(R) + 1;
  localparam int DEPTH = 1 << AW;
  localparam int BW    = 1 + UWO + DWO;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_i;
  logic [DWI-1:0] s_tdata;
  logic [UWI-1:0] s_tuser;
  logic           s_tlast;
  logic           s_tvalid;
  logic           s_tfull;
  logic           m_tready;
  logic [DWO-1:0] m_tdata;
  logic [UWO-1:0] m_tuser;
  logic           m_tlast;
  logic           m_tvalid;
  logic [LW-1:0]  m_tlevel;
  logic           m_tempty;

  axis_asym_fifo #(
    .DATA_WIDTH_IN   (DWI),
    .DATA_WIDTH_OUT  (DWO),
    .ADDRESS_WIDTH_IN(AW),
    .USER_WIDTH_IN   (UWI)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .s_axis_in_tdata  (s_tdata),
    .s_axis_in_tuser  (s_tuser),
    .s_axis_in_tlast  (s_tlast),
    .s_axis_in_tvalid (s_tvalid),
    .s_axis_in_tfull  (s_tfull),
    .m_axis_out_tready(m_tready),
    .m_axis_out_tdata (m_tdata),
    .m_axis_out_tuser (m_tuser),
    .m_axis_out_tlast (m_tlast),
    .m_axis_out_tvalid(m_tvalid),
    .m_axis_out_tlevel(m_tlevel),
    .m_axis_out_tempty(m_tempty)
  );

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_words();
    return (exp_q.size() + R - 1) / R;
  endfunction

  // ---------------- driver ----------------
  // Drive one clock of stimulus, check the outputs at the negative edge, then
  // advance the model by what the rising edge will do.
  task automatic step(input logic rst, input logic vld, input logic [DWI-1:0] d,
                      input logic [UWI-1:0] u, input logic l, input logic rdy);
    logic m_full;
    reset_i  = rst;
    s_tvalid = vld;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    m_tready = rdy;
    @(negedge clk);
    m_full = (model_words() == DEPTH);
    check_eq("tvalid", m_tvalid, exp_q.size() != 0);
    check_eq("tempty", m_tempty, exp_q.size() == 0);
    check_eq("tfull",  s_tfull,  m_full);
    check_eq("tlevel", m_tlevel, exp_q.size());
    if (exp_q.size() != 0) begin
      check_eq("beat", {m_tlast, m_tuser, m_tdata}, exp_q[0]);
    end
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (vld && !m_full) begin
        for (int i = 0; i < R; i++) begin
          exp_q.push_back({l && (i == R - 1), u[i*UWO +: UWO], d[i*DWO +: DWO]});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, '0, '0, 1'b0, rdy);
  endtask

  task automatic wr(input logic [DWI-1:0] d, input logic [UWI-1:0] u, input logic l,
                    input logic rdy);
    step(1'b0, 1'b1, d, u, l, rdy);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [DWI-1:0] w0;

    // 1 reset held for 3 clocks
    reset_i = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0; s_tlast = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    check_eq("rst_tvalid", m_tvalid, 0);
    check_eq("rst_tempty", m_tempty, 1);
    check_eq("rst_tfull",  s_tfull,  0);
    check_eq("rst_tlevel", m_tlevel, 0);
    check_eq("rst_tlast",  m_tlast,  0);

    // 2 slice order: low byte first, tlast on the last slice only
    wr(16'hB2A1, 4'b0101, 1'b1, 1'b1);
    check_eq("ord_b0", {m_tlast, m_tuser, m_tdata}, {1'b0, 2'b01, 8'hA1});
    check_eq("ord_lvl2", m_tlevel, 2);
    idle(1'b1);
    check_eq("ord_b1", {m_tlast, m_tuser, m_tdata}, {1'b1, 2'b01, 8'hB2});
    check_eq("ord_lvl1", m_tlevel, 1);
    idle(1'b1);
    check_eq("ord_lvl0", m_tlevel, 0);
    check_eq("ord_empty", m_tempty, 1);

    // 3 backpressure: output held, then 6 beats without gaps
    w0 = 16'($urandom);
    wr(w0, 4'($urandom), 1'b0, 1'b0);
    wr(16'($urandom), 4'($urandom), 1'b1, 1'b0);
    wr(16'($urandom), 4'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_hold", m_tdata, w0[7:0]);
      check_eq("bp_lvl", m_tlevel, 6);
      idle(1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      check_eq("bp_nogap", m_tvalid, 1);
      idle(1'b1);
    end
    check_eq("bp_drained", m_tlevel, 0);

    // 4 fill to the top; word 1025 must be dropped
    for (int i = 0; i < DEPTH + 1; i++) begin
      wr(16'(i), 4'(i), i[0], 1'b0);
      if (i == DEPTH - 1) check_eq("full_at_1024", s_tfull, 1);
      if (i == DEPTH - 2) check_eq("notfull_1023", s_tfull, 0);
    end
    check_eq("full_lvl", m_tlevel, 2 * DEPTH);
    // write against full while a final slice is read: still dropped
    idle(1'b1);
    wr(16'hDEAD, 4'hF, 1'b1, 1'b1);
    check_eq("full_drop_concurrent", m_tlevel, 2 * DEPTH - 2);
    for (int i = 0; i < 2 * DEPTH; i++) idle(1'b1);
    check_eq("full_drained", m_tempty, 1);

    // 5 concurrent streaming, one word per 2 clocks, wraps the pointers
    for (int i = 0; i < 5000; i++) begin
      wr(16'($urandom), 4'($urandom), 1'($urandom), 1'b1);
      check_eq("conc_bound", m_tlevel <= 2, 1);
      idle(1'b1);
    end
    idle(1'b1);
    check_eq("conc_end", m_tlevel, 0);

    // randomized traffic including full/empty corners
    for (int i = 0; i < 3000; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom), 1'($urandom),
           1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 2 * DEPTH + 2; i++) idle(1'b1);

    // 6 reset after the first slice of a word
    wr(16'h1234, 4'h6, 1'b1, 1'b0);
    wr(16'h5678, 4'h9, 1'b0, 1'b0);
    idle(1'b1);
    check_eq("mr_sub1", m_tdata, 8'h12);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    check_eq("mr_tvalid", m_tvalid, 0);
    check_eq("mr_tlevel", m_tlevel, 0);
    check_eq("mr_tlast",  m_tlast,  0);
    wr(16'hC3D4, 4'hA, 1'b1, 1'b1);
    check_eq("mr_new_b0", m_tdata, 8'hD4);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom), 1'($urandom), 1'b1);
    end
    for (int i = 0; i < 40; i++) idle(1'b1);
    check_eq("mr_end", m_tempty, 1);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
